// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin front end that shares one free-running,
// fixed-latency FP multiplier datapath between two requesters. Each issued
// operand pair is followed by a {valid, tag} pipeline so that the datapath
// result can be routed back to the requester that issued it.
module fp_mul_arbiter #(
  parameter int LAT = 3  // datapath latency, mul_in_valid -> mul_z, 1..8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        req1_ready,
  output logic        mul_in_valid,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [31:0] mul_z,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_z,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_z,
  output logic        busy
);

  logic           last_q, last_d;
  logic           issue_vld_q, issue_vld_d;
  logic           issue_id_q, issue_id_d;
  logic [31:0]    mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic           rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [31:0]    rsp0_z_q, rsp0_z_d, rsp1_z_q, rsp1_z_d;
  logic           gnt0, gnt1, hs;

  // Grant: sole valid requester wins; on contention the one that did not win last.
  // Forced off under reset/flush so nothing can enter while state is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !flush) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    hs = gnt0 | gnt1;
  end

  // Next state: issue register, tag shift register and response capture.
  always_comb begin
    last_d      = hs ? gnt1 : last_q;
    issue_vld_d = hs;
    issue_id_d  = gnt1;
    mul_x_d     = hs ? (gnt1 ? req1_x : req0_x) : mul_x_q;
    mul_y_d     = hs ? (gnt1 ? req1_y : req0_y) : mul_y_q;

    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue_vld_q;
    tag_id_d[0]  = issue_id_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    // The oldest tag lines up with mul_z in this cycle.
    rsp0_valid_d = tag_vld_q[LAT-1] && !tag_id_q[LAT-1];
    rsp1_valid_d = tag_vld_q[LAT-1] &&  tag_id_q[LAT-1];
    rsp0_z_d     = rsp0_valid_d ? mul_z : rsp0_z_q;
    rsp1_z_d     = rsp1_valid_d ? mul_z : rsp1_z_q;

    // Flush drops everything in flight, including a result arriving right now.
    if (flush) begin
      issue_vld_d  = 1'b0;
      tag_vld_d    = '0;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rsp0_z_d     = rsp0_z_q;
      rsp1_z_d     = rsp1_z_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      issue_vld_q  <= 1'b0;
      issue_id_q   <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_z_q     <= '0;
      rsp1_z_q     <= '0;
    end else begin
      last_q       <= last_d;
      issue_vld_q  <= issue_vld_d;
      issue_id_q   <= issue_id_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_z_q     <= rsp0_z_d;
      rsp1_z_q     <= rsp1_z_d;
    end
  end

  assign req0_ready   = gnt0;
  assign req1_ready   = gnt1;
  assign mul_in_valid = issue_vld_q;
  assign mul_x        = mul_x_q;
  assign mul_y        = mul_y_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_z       = rsp0_z_q;
  assign rsp1_z       = rsp1_z_q;
  assign busy         = issue_vld_q | (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: three instances (LAT = 1, 3, 8) share one stimulus
// stream; each has its own fixed-latency multiplier model. Expected results and
// handshake cycles go into per-requester queues; a forked monitor consumes them.
module tb_fp_mul_arbiter;

  localparam int NI = 3;
  localparam int LATS [NI] = '{1, 3, 8};
  localparam int MAIN = 1;  // LAT=3 instance drives handshake decisions

  // Hand-computed IEEE-754 single products.
  localparam logic [31:0] VX [8] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h3F000000,
                                     32'h3F800000, 32'hBF800000, 32'h41200000, 32'h40400000};
  localparam logic [31:0] VY [8] = '{32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F000000,
                                     32'h40E00000, 32'hBF800000, 32'h3F000000, 32'h40400000};
  localparam logic [31:0] VZ [8] = '{32'h40C00000, 32'h40100000, 32'hC1000000, 32'h3E800000,
                                     32'h40E00000, 32'h3F800000, 32'h40A00000, 32'h41100000};

  typedef struct {
    logic [31:0] z;
    int          h;
  } ent_t;

  logic        clk, rst, flush;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic        rdy0 [NI], rdy1 [NI], miv [NI], r0v [NI], r1v [NI], bsy [NI];
  logic [31:0] mx [NI], my [NI], mz [NI], r0z [NI], r1z [NI];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ent_t q0 [$];
  ent_t q1 [$];
  int   fq [$];
  int   rd0 [NI];
  int   rd1 [NI];

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    for (int k = 0; k < 8; k++)
      if (VX[k] === x && VY[k] === y) return VZ[k];
    return 32'hDEAD0000 ^ x;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g
      localparam int L = LATS[gi];
      logic [63:0] pipe [L];
      fp_mul_arbiter #(.LAT(L)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(rdy0[gi]),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(rdy1[gi]),
        .mul_in_valid(miv[gi]), .mul_x(mx[gi]), .mul_y(my[gi]), .mul_z(mz[gi]),
        .rsp0_valid(r0v[gi]), .rsp0_z(r0z[gi]), .rsp1_valid(r1v[gi]), .rsp1_z(r1z[gi]),
        .busy(bsy[gi])
      );
      // Free-running datapath model: result appears exactly L cycles after issue.
      always @(posedge clk) begin
        pipe[0] <= {mx[gi], my[gi]};
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign mz[gi] = model(pipe[L-1][63:32], pipe[L-1][31:0]);
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic bit dropped(input int h, input int l);
    foreach (fq[k]) if (h < fq[k] && fq[k] < h + 2 + l) return 1'b1;
    return 1'b0;
  endfunction

  // Pop the next non-flushed expectation for requester rq of instance i.
  function automatic void check_rsp(input int i, input int rq);
    int   l = LATS[i];
    int   r = (rq == 0) ? rd0[i] : rd1[i];
    int   n = (rq == 0) ? q0.size() : q1.size();
    ent_t e;
    logic [31:0] z = (rq == 0) ? r0z[i] : r1z[i];
    while (r < n && dropped((rq == 0) ? q0[r].h : q1[r].h, l)) r++;
    if (r >= n) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp%0d inst%0d at cycle %0d: got z=%h want no response", rq, i, cyc, z);
    end else begin
      e = (rq == 0) ? q0[r] : q1[r];
      chk($sformatf("rsp%0d_z inst%0d", rq, i), z, e.z);
      chk($sformatf("rsp%0d_latency inst%0d", rq, i), cyc - e.h, l + 2);
      r++;
    end
    if (rq == 0) rd0[i] = r; else rd1[i] = r;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (r0v[i] === 1'b1 || r1v[i] === 1'b1)
          chk($sformatf("rsp_exclusive inst%0d", i), {31'd0, r0v[i] & r1v[i]}, 32'd0);
        if (r0v[i] === 1'b1) check_rsp(i, 0);
        if (r1v[i] === 1'b1) check_rsp(i, 1);
      end
    end
  endtask

  // One cycle of stimulus. eg: expected grant 0 none, 1 req0, 2 req1.
  // eb: expected busy on all instances, or -1 to skip. g: observed grant.
  task automatic step(input logic v0, input int i0, input logic v1, input int i1,
                      input int eg, input int eb, output int g);
    req0_valid = v0; req0_x = VX[i0]; req0_y = VY[i0];
    req1_valid = v1; req1_x = VX[i1]; req1_y = VY[i1];
    @(negedge clk);
    chk("grant", {30'd0, rdy1[MAIN], rdy0[MAIN]}, eg[31:0]);
    if (eb >= 0)
      for (int i = 0; i < NI; i++) chk($sformatf("busy inst%0d", i), {31'd0, bsy[i]}, eb[31:0]);
    if (flush) fq.push_back(cyc);
    g = 0;
    if (v0 && rdy0[MAIN] === 1'b1) begin q0.push_back('{VZ[i0], cyc}); g = 1; end
    if (v1 && rdy1[MAIN] === 1'b1) begin q1.push_back('{VZ[i1], cyc}); g = 2; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0, 0, -1, g);
  endtask

  initial begin
    int g, i0, i1, rem;
    foreach (rd0[i]) begin rd0[i] = 0; rd1[i] = 0; end
    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    fork monitor(); join_none

    // Reset held two cycles with both requesters valid.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 0, 1'b1, 1, 0, 0, g);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("rst mul_in_valid inst%0d", i), {31'd0, miv[i]}, 32'd0);
        chk($sformatf("rst rsp_valid inst%0d", i), {30'd0, r1v[i], r0v[i]}, 32'd0);
        chk($sformatf("rst mul_x inst%0d", i), mx[i], 32'd0);
        chk($sformatf("rst mul_y inst%0d", i), my[i], 32'd0);
        chk($sformatf("rst rsp0_z inst%0d", i), r0z[i], 32'd0);
        chk($sformatf("rst rsp1_z inst%0d", i), r1z[i], 32'd0);
      end
    end
    rst = 1'b0;

    // First contention after reset goes to requester 0.
    step(1'b1, 0, 1'b1, 1, 1, -1, g);
    idle(12);

    // Single op 2.0 x 3.0 from requester 0, then everything drains.
    step(1'b1, 0, 1'b0, 0, 1, 0, g);
    idle(12);
    step(1'b0, 0, 1'b0, 0, 0, 0, g);

    // Requester 1 streams alone for five cycles.
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, 2 + k, 2, -1, g);
    idle(14);

    // Both valid for six cycles: grants alternate starting with requester 0.
    i0 = 0; i1 = 3;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, i0, 1'b1, i1, (k % 2 == 0) ? 1 : 2, -1, g);
      if (g == 1) i0++;
      if (g == 2) i1++;
    end
    idle(14);

    // Three ops, a gap, then flush: ready is low during flush, busy clears next cycle,
    // and a handshake in that cycle goes through normally.
    for (int k = 0; k < 3; k++) step(1'b1, 5 + k, 1'b0, 0, 1, -1, g);
    idle(1);
    flush = 1'b1;
    step(1'b1, 1, 1'b1, 2, 0, -1, g);
    flush = 1'b0;
    step(1'b0, 0, 1'b1, 7, 2, 0, g);
    idle(14);

    // Every non-flushed expectation must have been delivered.
    for (int i = 0; i < NI; i++) begin
      rem = 0;
      for (int r = rd0[i]; r < q0.size(); r++) if (!dropped(q0[r].h, LATS[i])) rem++;
      chk($sformatf("missing rsp0 inst%0d", i), rem, 32'd0);
      rem = 0;
      for (int r = rd1[i]; r < q1.size(); r++) if (!dropped(q1[r].h, LATS[i])) rem++;
      chk($sformatf("missing rsp1 inst%0d", i), rem, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin controller that shares one pipelined single-precision multiplier datapath (operand register stage, exponent addition, mantissa product, normalisation) between two requesters. It accepts operand pairs over valid/ready, issues at most one pair per cycle to the datapath, and tracks each in-flight operation with a requester tag. It captures the datapath result after the fixed datapath latency and returns it to the requester that issued it. It sits between the FPU issue logic and the multiplier datapath.

## Interface
- LAT, 3, datapath latency in cycles from `mul_in_valid` to valid `mul_z`; legal range 1..8
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all in-flight operations
- req0_valid  in  1  requester 0 has an operand pair
- req0_x, req0_y  in  32  requester 0 IEEE-754 single operands
- req0_ready  out  1  grant to requester 0; handshake = valid & ready
- req1_valid, req1_x, req1_y, req1_ready  same as requester 0, for requester 1
- mul_in_valid  out  1  operand pair on `mul_x`/`mul_y` is issued this cycle
- mul_x, mul_y  out  32  operands to the datapath (sign, exponent `[30:23]`, mantissa `[22:0]`)
- mul_z  in  32  datapath result, sampled exactly LAT cycles after the matching `mul_in_valid`
- rsp0_valid, rsp1_valid  out  1  one-cycle pulse: result for that requester
- rsp0_z, rsp1_z  out  32  result, held until the next pulse for that requester
- busy  out  1  any operation in flight or pending response

## Operation
- Arbitration is round-robin on a 1-bit `last` pointer:
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to `last` is granted.
  - `last` updates to the granted requester on each handshake.
  - After reset, `last` = 1, so requester 0 wins the first contention.
- `reqN_ready` is combinational from the valids and `last`. It is 0 while RST or flush is high. At most one ready is high per cycle, and it never depends on the datapath because the datapath has no backpressure.
- Issue register: on a handshake in cycle t, `mul_x`/`mul_y` load the granted operands and `mul_in_valid` = 1 in cycle t+1. With no handshake, `mul_in_valid` = 0 and `mul_x`/`mul_y` hold their value.
- Tag pipeline: shift register of LAT entries {valid, tag}. Entry 0 loads {`mul_in_valid`, requester id of the issued pair}; each entry advances every cycle.
- Capture: when the last tag entry is valid, `mul_z` is registered into `rspT_z` and `rspT_valid` pulses for one cycle next cycle, where T is the tag.
- Throughput: one operation per cycle sustained. Both requesters continuously valid → grants alternate 0,1,0,1.
- flush:
  - Clears the issue-valid register, all tag valid bits and both rsp_valid in the same edge.
  - `rsp_z` values and `last` are kept.
  - Results of flushed operations are never delivered.
- RST: same clearing as flush, plus `last` = 1 and `mul_x`, `mul_y`, `rsp0_z`, `rsp1_z` = 0. RST asserted mid-operation drops every in-flight result.
- `busy` = `mul_in_valid` | any tag valid | `rsp0_valid` | `rsp1_valid`.

## Timing
- Reset values:
  - `req0_ready`, `req1_ready`, `mul_in_valid`, `rsp0_valid`, `rsp1_valid`, `busy` = 0
  - `mul_x`, `mul_y`, `rsp0_z`, `rsp1_z` = 0
  - internal `last` = 1
- Latency: handshake at edge t → `mul_in_valid` at t+1 → `mul_z` valid at t+1+LAT → `rspN_valid` at t+2+LAT. Total is LAT+2 cycles.
- Responses leave in issue order. Each requester gets its results in its own handshake order.
- Both `rsp0_valid` and `rsp1_valid` are never high in the same cycle.
- A handshake in the same cycle as flush is impossible because ready is forced low.
- A handshake in the cycle after flush deasserts proceeds normally.
- The datapath is required to be free-running with no stall. `mul_z` in cycles without a matching tag is ignored.

## Test plan
- Reset: hold RST 2 cycles with both valids high → both ready 0, all outputs 0. First cycle after release, both valid → req0 granted.
- Single op, LAT=3: req0 handshake at cycle 10 with x=0x40000000, y=0x40400000 (2.0×3.0); model returns 0x40C00000 → `rsp0_valid` pulses only at cycle 15 with `rsp0_z`=0x40C00000.
- Contention: both valid for 6 cycles → grants 0,1,0,1,0,1. Six responses arrive back-to-back, alternating rsp0/rsp1, in issue order.
- Single requester streaming: req1 valid for 5 cycles with req0 idle → req1_ready high every cycle, 5 consecutive `rsp1_valid` pulses, no `rsp0_valid`.
- Flush mid-flight: issue 3 ops, assert flush 2 cycles later → no responses for those ops, `busy` 0 the cycle after flush. The next issued op returns normally after LAT+2.
- Parameter sweep: repeat the single-op case with LAT=1 and LAT=8 → response exactly LAT+2 cycles after the handshake.
